req_dispatch_ctrl: RTL and testbench
====================================

# req_dispatch_ctrl

Dispatch controller between the 1-deep CPU request buffer and the two accelerator FSMs (AES, SHA). It takes the buffered request and decodes the opcode to pick the target engine. It issues a one-cycle start with latched operands, tracks each engine's IDLE/ISSUE/BUSY/CPL lifecycle, and drives the `free_aes`/`free_sha` back-pressure into the buffer. Finished jobs are reported to the CPU side through a round-robin-arbitrated completion handshake.

## Interface
- ADDR_W, 10, text/key address width
- ADDR_W_ENCODING_W, 3, text width encoding width
- CPU_OPCODE_W, 2, opcode width; encodings fixed by cpu_opcode_map.svh: AES_ENC=0, AES_DEC=1, SHA_ENC=2, SHA_DEC=3

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  1  buffered request valid
- req_ready  out  1  request accepted this cycle when high with req_valid
- req_text_addr  in  ADDR_W  text address
- req_text_width  in  ADDR_W_ENCODING_W  text width code
- req_key_addr  in  ADDR_W  key address (ignored for SHA)
- req_opcode  in  CPU_OPCODE_W  operation
- aes_start  out  1  one-cycle start pulse to AES FSM
- aes_text_addr / aes_key_addr  out  ADDR_W  latched operands
- aes_text_width  out  ADDR_W_ENCODING_W  latched width
- aes_decrypt  out  1  1 for AES_DEC
- aes_done  in  1  AES job finished (pulse)
- sha_start  out  1  one-cycle start pulse to SHA FSM
- sha_text_addr  out  ADDR_W; sha_text_width  out  ADDR_W_ENCODING_W  latched operands
- sha_dec  out  1  1 for SHA_DEC
- sha_done  in  1  SHA job finished (pulse)
- free_aes / free_sha  out  1  engine in IDLE
- cpl_valid  out  1  completion pending
- cpl_ready  in  1  CPU side consumes completion
- cpl_engine  out  1  0=AES, 1=SHA
- cpl_opcode  out  CPU_OPCODE_W  opcode of the completed job
- err_sticky  out  1  protocol error seen since reset

## Operation
- Each engine has an independent FSM with states IDLE, ISSUE, BUSY and CPL.
  - IDLE→ISSUE on accept of a request targeting this engine.
  - ISSUE→BUSY unconditionally after 1 cycle; start=1 only in ISSUE.
  - BUSY→CPL on done.
  - CPL→IDLE when this engine's completion is handed over (cpl_valid && cpl_ready && selected).
- Target decode: opcode[1]=0 → AES, 1 → SHA.
- req_ready = target engine in IDLE, decoded combinationally from req_opcode.
- Operands and opcode latch on accept and are held stable until the engine returns to IDLE.
- aes_decrypt = latched opcode==AES_DEC. sha_dec = latched opcode==SHA_DEC.
- free_x = (state_x==IDLE). Both engines may be busy concurrently.
- Completion arbitration:
  - cpl_valid = any engine in CPL.
  - If only one engine is in CPL, it is selected.
  - If both are in CPL, the round-robin pointer selects. The pointer resets to AES and flips to the other engine after each handshake.
  - cpl_engine/cpl_opcode are held stable while cpl_valid && !cpl_ready.
- Protocol errors set err_sticky, which is cleared only by reset:
  - done asserted while that engine is not in BUSY; the done is otherwise ignored.
  - req_valid with X opcode is not checked.

## Timing
- Reset (rst_n=0 at an edge) forces:
  - all FSMs to IDLE and the pointer to AES;
  - aes_start=sha_start=0, cpl_valid=0, err_sticky=0, free_aes=free_sha=1;
  - all latched operand outputs, aes_decrypt and sha_dec to 0.
- Reset mid-job aborts it silently; no completion is reported.
- Accept at edge N → start high during cycle N+1 only → BUSY from N+2.
- done is honoured from cycle N+2. done in cycle N+1 (ISSUE) is an error.
- done sampled at edge M → cpl_valid high from M+1.
- Handshake at edge K → engine free from K+1, so a new accept for it is possible at edge K+1.
- Minimum accept-to-accept on one engine: 4 cycles (done at N+2, cpl_ready held high).
- Simultaneous events:
  - Accept for one engine and done/handshake on the other in the same cycle are independent.
  - Both dones in the same cycle: both enter CPL; the pointer orders reporting.

## Test plan
- Reset then req AES_ENC (text_addr=0x12A, width=3, key=0x055), done 5 cycles after start, cpl_ready=1 → aes_start is a single pulse at N+1 with those operands and aes_decrypt=0. cpl_valid is high 1 cycle after done with cpl_engine=0, cpl_opcode=0. free_aes is 0 from N+1 until the handshake.
- AES busy, then req AES_DEC → req_ready=0 and the request is held. It is accepted the cycle after the AES handshake, with aes_decrypt=1.
- AES busy and req SHA_DEC arrives → accepted immediately and sha_start pulses while AES is still BUSY. sha_dec=1.
- Both engines done in the same cycle with cpl_ready=1 → completions come out AES then SHA on consecutive cycles. Repeat with pointer at SHA → SHA then AES.
- Completions are produced with cpl_ready=0 for 3 cycles → cpl_valid and cpl_opcode stay stable and no engine returns to IDLE.
- Two fault cases:
  - sha_done pulsed while SHA is IDLE → err_sticky=1 and no completion.
  - rst_n=0 for 1 cycle during AES BUSY → all outputs at reset values, and a later stray aes_done sets err_sticky.

Source files
------------

// File: rtl/req_dispatch_ctrl.sv
// Dispatches buffered CPU requests to the AES/SHA engines, runs a per-engine
// IDLE/ISSUE/BUSY/CPL lifecycle and round-robin arbitrates the completion handshake.
module req_dispatch_ctrl #(
    parameter int ADDR_W            = 10,
    parameter int ADDR_W_ENCODING_W = 3,
    parameter int CPU_OPCODE_W      = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [ADDR_W-1:0]            req_text_addr,
    input  logic [ADDR_W_ENCODING_W-1:0] req_text_width,
    input  logic [ADDR_W-1:0]            req_key_addr,
    input  logic [CPU_OPCODE_W-1:0]      req_opcode,
    output logic                         aes_start,
    output logic [ADDR_W-1:0]            aes_text_addr,
    output logic [ADDR_W-1:0]            aes_key_addr,
    output logic [ADDR_W_ENCODING_W-1:0] aes_text_width,
    output logic                         aes_decrypt,
    input  logic                         aes_done,
    output logic                         sha_start,
    output logic [ADDR_W-1:0]            sha_text_addr,
    output logic [ADDR_W_ENCODING_W-1:0] sha_text_width,
    output logic                         sha_dec,
    input  logic                         sha_done,
    output logic                         free_aes,
    output logic                         free_sha,
    output logic                         cpl_valid,
    input  logic                         cpl_ready,
    output logic                         cpl_engine,
    output logic [CPU_OPCODE_W-1:0]      cpl_opcode,
    output logic                         err_sticky
);
    localparam logic [CPU_OPCODE_W-1:0] AES_DEC = CPU_OPCODE_W'(1);
    localparam logic [CPU_OPCODE_W-1:0] SHA_DEC = CPU_OPCODE_W'(3);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;
    localparam logic [1:0] ST_CPL   = 2'd3;

    logic              req_tgt;
    logic              accept;
    logic [1:0]        done_vec;
    logic [1:0]        idle_vec;
    logic [1:0]        cpl_vec;
    logic [1:0]        err_vec;
    logic              arb_sel;
    logic              cpl_sel;
    logic              handshake;
    logic              rr_q;
    logic              hold_q;
    logic              hold_sel_q;
    logic              err_q;
    logic [ADDR_W-1:0] key_addr_q;

    assign req_tgt   = req_opcode[1];
    assign req_ready = idle_vec[req_tgt];
    assign accept    = req_valid && req_ready;
    assign done_vec  = {sha_done, aes_done};

    // Engine index 0 is AES, 1 is SHA.
    for (genvar gi = 0; gi < 2; gi++) begin : g_eng
        localparam logic ENG = (gi == 1);

        logic [1:0]                   state_q;
        logic [1:0]                   state_d;
        logic [ADDR_W-1:0]            text_addr_q;
        logic [ADDR_W_ENCODING_W-1:0] text_width_q;
        logic [CPU_OPCODE_W-1:0]      opcode_q;
        logic                         take;

        assign take         = accept && (req_tgt == ENG);
        assign idle_vec[gi] = (state_q == ST_IDLE);
        assign cpl_vec[gi]  = (state_q == ST_CPL);
        // A done outside BUSY is flagged and otherwise has no effect.
        assign err_vec[gi]  = done_vec[gi] && (state_q != ST_BUSY);

        always_comb begin
            state_d = state_q;
            case (state_q)
                ST_IDLE:  if (take) state_d = ST_ISSUE;
                ST_ISSUE: state_d = ST_BUSY;
                ST_BUSY:  if (done_vec[gi]) state_d = ST_CPL;
                ST_CPL:   if (handshake && (cpl_sel == ENG)) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q      <= ST_IDLE;
                text_addr_q  <= '0;
                text_width_q <= '0;
                opcode_q     <= '0;
            end else begin
                state_q <= state_d;
                if (take) begin
                    text_addr_q  <= req_text_addr;
                    text_width_q <= req_text_width;
                    opcode_q     <= req_opcode;
                end
            end
        end
    end

    // Once a completion is shown without being taken, the selection is frozen
    // so a late arrival on the other engine cannot swap what the CPU sees.
    assign arb_sel   = (cpl_vec[0] && cpl_vec[1]) ? rr_q : cpl_vec[1];
    assign cpl_sel   = hold_q ? hold_sel_q : arb_sel;
    assign cpl_valid = |cpl_vec;
    assign handshake = cpl_valid && cpl_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q       <= 1'b0;
            hold_q     <= 1'b0;
            hold_sel_q <= 1'b0;
            err_q      <= 1'b0;
            key_addr_q <= '0;
        end else begin
            if (handshake) rr_q <= ~rr_q;
            hold_q     <= cpl_valid && !cpl_ready;
            hold_sel_q <= cpl_sel;
            err_q      <= err_q | (|err_vec);
            if (accept && !req_tgt) key_addr_q <= req_key_addr;
        end
    end

    assign aes_start      = (g_eng[0].state_q == ST_ISSUE);
    assign aes_text_addr  = g_eng[0].text_addr_q;
    assign aes_text_width = g_eng[0].text_width_q;
    assign aes_key_addr   = key_addr_q;
    assign aes_decrypt    = (g_eng[0].opcode_q == AES_DEC);

    assign sha_start      = (g_eng[1].state_q == ST_ISSUE);
    assign sha_text_addr  = g_eng[1].text_addr_q;
    assign sha_text_width = g_eng[1].text_width_q;
    assign sha_dec        = (g_eng[1].opcode_q == SHA_DEC);

    assign free_aes   = idle_vec[0];
    assign free_sha   = idle_vec[1];
    assign cpl_engine = cpl_sel;
    assign cpl_opcode = cpl_sel ? g_eng[1].opcode_q : g_eng[0].opcode_q;
    assign err_sticky = err_q;
endmodule

// File: tb/tb_req_dispatch_ctrl.sv
// Bench for req_dispatch_ctrl: directed scenarios with constant expectations,
// then a long random run checked against a job/timestamp reference model.
module tb_req_dispatch_ctrl;
    localparam int AW = 10;
    localparam int EW = 3;
    localparam int OW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_text_addr;
    logic [EW-1:0] req_text_width;
    logic [AW-1:0] req_key_addr;
    logic [OW-1:0] req_opcode;
    logic          aes_start;
    logic [AW-1:0] aes_text_addr;
    logic [AW-1:0] aes_key_addr;
    logic [EW-1:0] aes_text_width;
    logic          aes_decrypt;
    logic          aes_done;
    logic          sha_start;
    logic [AW-1:0] sha_text_addr;
    logic [EW-1:0] sha_text_width;
    logic          sha_dec;
    logic          sha_done;
    logic          free_aes;
    logic          free_sha;
    logic          cpl_valid;
    logic          cpl_ready;
    logic          cpl_engine;
    logic [OW-1:0] cpl_opcode;
    logic          err_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    req_dispatch_ctrl #(
        .ADDR_W(AW), .ADDR_W_ENCODING_W(EW), .CPU_OPCODE_W(OW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_text_addr(req_text_addr), .req_text_width(req_text_width),
        .req_key_addr(req_key_addr), .req_opcode(req_opcode),
        .aes_start(aes_start), .aes_text_addr(aes_text_addr),
        .aes_key_addr(aes_key_addr), .aes_text_width(aes_text_width),
        .aes_decrypt(aes_decrypt), .aes_done(aes_done),
        .sha_start(sha_start), .sha_text_addr(sha_text_addr),
        .sha_text_width(sha_text_width), .sha_dec(sha_dec), .sha_done(sha_done),
        .free_aes(free_aes), .free_sha(free_sha),
        .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
        .cpl_engine(cpl_engine), .cpl_opcode(cpl_opcode),
        .err_sticky(err_sticky)
    );

    // Reference model: a job exists from accept until its completion is taken;
    // m_issue is the cycle index in which its start pulse belongs.
    bit            m_job [2];
    bit            m_fin [2];
    int            m_issue [2];
    logic [OW-1:0] m_op [2];
    logic [AW-1:0] m_text [2];
    logic [EW-1:0] m_width [2];
    logic [AW-1:0] m_key;
    bit            m_ptr, m_err, m_lock, m_held;
    int            cyc = 0;
    logic          mv, ms;

    assign mv = m_fin[0] | m_fin[1];
    assign ms = m_lock ? m_held : ((m_fin[0] && m_fin[1]) ? m_ptr : m_fin[1]);

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int e = 0; e < 2; e++) begin
                m_job[e] <= 1'b0; m_fin[e] <= 1'b0;
                m_op[e] <= '0; m_text[e] <= '0; m_width[e] <= '0;
            end
            m_key <= '0; m_ptr <= 1'b0; m_err <= 1'b0; m_lock <= 1'b0; m_held <= 1'b0;
        end else begin
            for (int e = 0; e < 2; e++) begin
                if ((e == 0) ? aes_done : sha_done) begin
                    if (m_job[e] && !m_fin[e] && cyc > m_issue[e]) m_fin[e] <= 1'b1;
                    else m_err <= 1'b1;
                end
            end
            if (mv && cpl_ready) begin
                m_job[ms] <= 1'b0; m_fin[ms] <= 1'b0; m_ptr <= !m_ptr;
            end
            if (req_valid && !m_job[req_opcode[1]]) begin
                m_job[req_opcode[1]]   <= 1'b1;
                m_issue[req_opcode[1]] <= cyc + 1;
                m_op[req_opcode[1]]    <= req_opcode;
                m_text[req_opcode[1]]  <= req_text_addr;
                m_width[req_opcode[1]] <= req_text_width;
                if (!req_opcode[1]) m_key <= req_key_addr;
            end
            m_lock <= mv && !cpl_ready;
            m_held <= ms;
        end
        cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (rst_n && cpl_valid && cpl_ready)
            $display("[%0t] completion engine=%0d opcode=%0d", $time, cpl_engine, cpl_opcode);
    end

    task automatic drive_req(input logic [OW-1:0] op, input logic [AW-1:0] ta,
                             input logic [EW-1:0] tw, input logic [AW-1:0] ka);
        req_valid = 1'b1; req_opcode = op; req_text_addr = ta;
        req_text_width = tw; req_key_addr = ka;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({free_aes, free_sha} !== 2'b11) begin n_fail++; $display("FAIL reset_free: got %b want 11", {free_aes, free_sha}); end
        n_checks++; if ({aes_start, sha_start, cpl_valid, err_sticky} !== 4'b0000) begin n_fail++; $display("FAIL reset_ctl: start/start/cpl/err got %b want 0000", {aes_start, sha_start, cpl_valid, err_sticky}); end
        n_checks++; if ({aes_text_addr, aes_text_width, aes_key_addr, sha_text_addr, sha_text_width, aes_decrypt, sha_dec} !== '0) begin n_fail++; $display("FAIL reset_operands: not all zero aes_ta=%h sha_ta=%h", aes_text_addr, sha_text_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aes_basic();
        cpl_ready = 1'b1;
        drive_req(2'd0, 10'h12A, 3'd3, 10'h055);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (aes_start !== 1'b1) begin n_fail++; $display("FAIL basic_start: got %b want 1", aes_start); end
        n_checks++; if ({aes_text_addr, aes_text_width, aes_key_addr} !== {10'h12A, 3'd3, 10'h055}) begin n_fail++; $display("FAIL basic_operands: got %h/%0d/%h want 12a/3/055", aes_text_addr, aes_text_width, aes_key_addr); end
        n_checks++; if ({aes_decrypt, free_aes, sha_start} !== 3'b000) begin n_fail++; $display("FAIL basic_flags: dec/free/sha_start got %b want 000", {aes_decrypt, free_aes, sha_start}); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if ({aes_start, cpl_valid, free_aes} !== 3'b000) begin n_fail++; $display("FAIL basic_busy%0d: start/cpl/free got %b want 000", k, {aes_start, cpl_valid, free_aes}); end
        end
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        n_checks++; if ({cpl_valid, cpl_engine, cpl_opcode, free_aes} !== 5'b10000) begin n_fail++; $display("FAIL basic_cpl: valid/eng/op/free got %b want 10000", {cpl_valid, cpl_engine, cpl_opcode, free_aes}); end
        @(negedge clk);
        n_checks++; if ({cpl_valid, free_aes} !== 2'b01) begin n_fail++; $display("FAIL basic_after_hs: valid/free got %b want 01", {cpl_valid, free_aes}); end
    endtask

    task automatic test_aes_blocked();
        drive_req(2'd0, 10'h0A0, 3'd1, 10'h3FF);
        @(negedge clk);
        drive_req(2'd1, 10'h155, 3'd2, 10'h2AA);
        #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL blocked_ready_issue: got %b want 0", req_ready); end
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL blocked_ready_busy: got %b want 0", req_ready); end
        n_checks++; if (aes_text_addr !== 10'h0A0) begin n_fail++; $display("FAIL blocked_hold_addr: got %h want 0a0", aes_text_addr); end
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        n_checks++; if ({cpl_valid, req_ready} !== 2'b10) begin n_fail++; $display("FAIL blocked_cpl: valid/ready got %b want 10", {cpl_valid, req_ready}); end
        @(negedge clk);
        n_checks++; if ({free_aes, req_ready, cpl_valid} !== 3'b110) begin n_fail++; $display("FAIL blocked_freed: free/ready/valid got %b want 110", {free_aes, req_ready, cpl_valid}); end
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if ({aes_start, aes_decrypt, aes_text_addr} !== {2'b11, 10'h155}) begin n_fail++; $display("FAIL blocked_dec_start: start/dec/addr got %b/%b/%h want 1/1/155", aes_start, aes_decrypt, aes_text_addr); end
        @(negedge clk);
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        n_checks++; if ({cpl_valid, cpl_opcode} !== 3'b101) begin n_fail++; $display("FAIL blocked_cpl_op: valid/op got %b want 101", {cpl_valid, cpl_opcode}); end
        @(negedge clk);
    endtask

    task automatic test_concurrent();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive_req(2'd0, 10'h100, 3'd4, 10'h011);
        @(negedge clk);
        drive_req(2'd3, 10'h2F0, 3'd5, 10'h000);
        #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL conc_ready: got %b want 1", req_ready); end
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if ({sha_start, sha_dec, free_aes, aes_start} !== 4'b1100) begin n_fail++; $display("FAIL conc_sha_start: start/dec/free_aes/aes_start got %b want 1100", {sha_start, sha_dec, free_aes, aes_start}); end
        n_checks++; if ({sha_text_addr, sha_text_width} !== {10'h2F0, 3'd5}) begin n_fail++; $display("FAIL conc_sha_operands: got %h/%0d want 2f0/5", sha_text_addr, sha_text_width); end
        @(negedge clk);
        aes_done = 1'b1; sha_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0; sha_done = 1'b0;
        n_checks++; if ({cpl_valid, cpl_engine, cpl_opcode} !== 4'b1000) begin n_fail++; $display("FAIL both_first: valid/eng/op got %b want 1000", {cpl_valid, cpl_engine, cpl_opcode}); end
        @(negedge clk);
        n_checks++; if ({cpl_valid, cpl_engine, cpl_opcode, free_aes} !== 5'b11111) begin n_fail++; $display("FAIL both_second: valid/eng/op/free_aes got %b want 11111", {cpl_valid, cpl_engine, cpl_opcode, free_aes}); end
        @(negedge clk);
        n_checks++; if ({cpl_valid, free_sha} !== 2'b01) begin n_fail++; $display("FAIL both_drained: valid/free_sha got %b want 01", {cpl_valid, free_sha}); end
    endtask

    task automatic test_pointer_at_sha();
        drive_req(2'd2, 10'h001, 3'd0, 10'h000);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        sha_done = 1'b1;
        @(negedge clk);
        sha_done = 1'b0;
        n_checks++; if ({cpl_valid, cpl_engine, cpl_opcode} !== 4'b1110) begin n_fail++; $display("FAIL ptr_single: valid/eng/op got %b want 1110", {cpl_valid, cpl_engine, cpl_opcode}); end
        @(negedge clk);
        drive_req(2'd1, 10'h3AB, 3'd6, 10'h123);
        @(negedge clk);
        drive_req(2'd2, 10'h0CD, 3'd7, 10'h000);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        aes_done = 1'b1; sha_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0; sha_done = 1'b0;
        n_checks++; if ({cpl_valid, cpl_engine, cpl_opcode} !== 4'b1110) begin n_fail++; $display("FAIL ptr_sha_first: valid/eng/op got %b want 1110", {cpl_valid, cpl_engine, cpl_opcode}); end
        @(negedge clk);
        n_checks++; if ({cpl_valid, cpl_engine, cpl_opcode} !== 4'b1001) begin n_fail++; $display("FAIL ptr_aes_second: valid/eng/op got %b want 1001", {cpl_valid, cpl_engine, cpl_opcode}); end
        @(negedge clk);
        n_checks++; if (cpl_valid !== 1'b0) begin n_fail++; $display("FAIL ptr_drained: got %b want 0", cpl_valid); end
    endtask

    task automatic test_backpressure();
        cpl_ready = 1'b0;
        drive_req(2'd0, 10'h0F0, 3'd2, 10'h00F);
        @(negedge clk);
        drive_req(2'd3, 10'h30F, 3'd1, 10'h000);
        @(negedge clk);
        req_valid = 1'b0;
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        sha_done = 1'b1;
        @(negedge clk);
        sha_done = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_checks++; if ({cpl_valid, cpl_engine, cpl_opcode, free_aes, free_sha} !== 6'b100000) begin n_fail++; $display("FAIL bp_hold%0d: valid/eng/op/free/free got %b want 100000", k, {cpl_valid, cpl_engine, cpl_opcode, free_aes, free_sha}); end
            @(negedge clk);
        end
        cpl_ready = 1'b1;
        @(negedge clk);
        n_checks++; if ({cpl_valid, cpl_engine, cpl_opcode, free_aes} !== 5'b11111) begin n_fail++; $display("FAIL bp_release: valid/eng/op/free_aes got %b want 11111", {cpl_valid, cpl_engine, cpl_opcode, free_aes}); end
        @(negedge clk);
        n_checks++; if ({cpl_valid, free_aes, free_sha} !== 3'b011) begin n_fail++; $display("FAIL bp_drained: valid/free/free got %b want 011", {cpl_valid, free_aes, free_sha}); end
    endtask

    task automatic test_stray_done();
        n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL stray_pre_err: got %b want 0", err_sticky); end
        sha_done = 1'b1;
        @(negedge clk);
        sha_done = 1'b0;
        n_checks++; if ({err_sticky, cpl_valid, free_sha} !== 3'b101) begin n_fail++; $display("FAIL stray_sha: err/valid/free got %b want 101", {err_sticky, cpl_valid, free_sha}); end
        @(negedge clk);
        n_checks++; if ({err_sticky, cpl_valid} !== 2'b10) begin n_fail++; $display("FAIL stray_sticky: err/valid got %b want 10", {err_sticky, cpl_valid}); end
    endtask

    task automatic test_reset_midjob();
        drive_req(2'd1, 10'h3C3, 3'd7, 10'h1E1);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++; if ({free_aes, free_sha, cpl_valid, err_sticky, aes_start, aes_decrypt} !== 6'b110000) begin n_fail++; $display("FAIL midrst_ctl: free/free/valid/err/start/dec got %b want 110000", {free_aes, free_sha, cpl_valid, err_sticky, aes_start, aes_decrypt}); end
        n_checks++; if ({aes_text_addr, aes_text_width, aes_key_addr} !== '0) begin n_fail++; $display("FAIL midrst_operands: got %h/%0d/%h want 0/0/0", aes_text_addr, aes_text_width, aes_key_addr); end
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
        n_checks++; if ({err_sticky, cpl_valid, free_aes} !== 3'b101) begin n_fail++; $display("FAIL midrst_stray: err/valid/free got %b want 101", {err_sticky, cpl_valid, free_aes}); end
    endtask

    task automatic test_random();
        bit legal;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            n_checks++; if ({free_aes, free_sha} !== {!m_job[0], !m_job[1]}) begin n_fail++; $display("FAIL rnd_free @%0d: got %b want %b", i, {free_aes, free_sha}, {!m_job[0], !m_job[1]}); end
            n_checks++; if ({aes_start, sha_start} !== {m_job[0] && cyc == m_issue[0], m_job[1] && cyc == m_issue[1]}) begin n_fail++; $display("FAIL rnd_start @%0d: got %b", i, {aes_start, sha_start}); end
            n_checks++; if (req_ready !== !m_job[req_opcode[1]]) begin n_fail++; $display("FAIL rnd_ready @%0d: got %b want %b", i, req_ready, !m_job[req_opcode[1]]); end
            n_checks++; if (cpl_valid !== mv) begin n_fail++; $display("FAIL rnd_cpl_valid @%0d: got %b want %b", i, cpl_valid, mv); end
            if (mv) begin
                n_checks++; if ({cpl_engine, cpl_opcode} !== {ms, m_op[ms]}) begin n_fail++; $display("FAIL rnd_cpl_sel @%0d: eng/op got %b/%0d want %b/%0d", i, cpl_engine, cpl_opcode, ms, m_op[ms]); end
            end
            n_checks++; if (err_sticky !== m_err) begin n_fail++; $display("FAIL rnd_err @%0d: got %b want %b", i, err_sticky, m_err); end
            n_checks++; if ({aes_text_addr, aes_text_width, aes_key_addr, aes_decrypt} !== {m_text[0], m_width[0], m_key, m_op[0] == 2'd1}) begin n_fail++; $display("FAIL rnd_aes_ops @%0d: got %h/%0d/%h/%b", i, aes_text_addr, aes_text_width, aes_key_addr, aes_decrypt); end
            n_checks++; if ({sha_text_addr, sha_text_width, sha_dec} !== {m_text[1], m_width[1], m_op[1] == 2'd3}) begin n_fail++; $display("FAIL rnd_sha_ops @%0d: got %h/%0d/%b", i, sha_text_addr, sha_text_width, sha_dec); end
            rst_n          = ($urandom_range(0, 299) != 0);
            req_valid      = 1'($urandom_range(0, 1));
            req_opcode     = OW'($urandom);
            req_text_addr  = AW'($urandom);
            req_text_width = EW'($urandom);
            req_key_addr   = AW'($urandom);
            legal    = m_job[0] && !m_fin[0] && cyc > m_issue[0];
            aes_done = legal ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
            legal    = m_job[1] && !m_fin[1] && cyc > m_issue[1];
            sha_done = legal ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 199) == 0);
            cpl_ready = ($urandom_range(0, 3) != 0);
        end
        rst_n = 1'b1; req_valid = 1'b0; aes_done = 1'b0; sha_done = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_opcode = '0; req_text_addr = '0;
        req_text_width = '0; req_key_addr = '0; aes_done = 1'b0; sha_done = 1'b0;
        cpl_ready = 1'b0;
        test_reset();
        test_aes_basic();
        test_aes_blocked();
        test_concurrent();
        test_pointer_at_sha();
        test_backpressure();
        test_stray_done();
        test_reset_midjob();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
